// File: rtl/tinyalu_pkg.sv
// Shared opcode/state types and the op classification helper for the TinyALU family.
package tinyalu_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_SUB = 3'b101,
        OP_OR  = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_e;

    // Ops that always finish one cycle after acceptance (the illegal op
    // also finishes immediately, flagging err). MUL and NOP are excluded.
    function automatic logic is_single_cycle(input op_e op);
        case (op)
            OP_ADD, OP_AND, OP_XOR, OP_SUB, OP_OR, OP_ILL: is_single_cycle = 1'b1;
            default:                                       is_single_cycle = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tinyalu_wide_if.sv
// Start/done command interface of the wide TinyALU.
interface tinyalu_wide_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         op;
    logic               start;
    logic               done;
    logic               busy;
    logic               err;
    logic [2*WIDTH-1:0] result;

    modport master (
        output A, B, op, start,
        input  done, busy, err, result
    );

    modport slave (
        input  A, B, op, start,
        output done, busy, err, result
    );
endinterface

// File: rtl/tinyalu_mul_pipe.sv
// Unsigned multiplier with registered inputs and MULT_LAT-1 register stages;
// the valid bit travels with the data. With MULT_LAT=1 it is purely combinational.
module tinyalu_mul_pipe
    import tinyalu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW     = 2 * WIDTH;
    localparam int STAGES = MULT_LAT - 1;

    generate
        if (STAGES == 0) begin : g_comb
            logic unused_clk_rst_s;
            assign unused_clk_rst_s = clk ^ reset_n;
            assign product   = PW'(a) * PW'(b);
            assign out_valid = in_valid;
        end else begin : g_pipe
            logic [WIDTH-1:0]  a_r;
            logic [WIDTH-1:0]  b_r;
            logic [STAGES-1:0] vld_r;

            // Operand capture and valid shift register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_r   <= {WIDTH{1'b0}};
                    b_r   <= {WIDTH{1'b0}};
                    vld_r <= {STAGES{1'b0}};
                end else begin
                    a_r      <= a;
                    b_r      <= b;
                    vld_r[0] <= in_valid;
                    for (int i = 1; i < STAGES; i++) begin
                        vld_r[i] <= vld_r[i-1];
                    end
                end
            end

            if (STAGES == 1) begin : g_one
                assign product   = PW'(a_r) * PW'(b_r);
                assign out_valid = vld_r[0];
            end else begin : g_deep
                logic [PW-1:0] prod_r [STAGES-1];

                // Product pipeline behind the operand registers.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        for (int i = 0; i < STAGES - 1; i++) begin
                            prod_r[i] <= {PW{1'b0}};
                        end
                    end else begin
                        prod_r[0] <= PW'(a_r) * PW'(b_r);
                        for (int i = 1; i < STAGES - 1; i++) begin
                            prod_r[i] <= prod_r[i-1];
                        end
                    end
                end

                assign product   = prod_r[STAGES-2];
                assign out_valid = vld_r[STAGES-1];
            end
        end
    endgenerate
endmodule

// File: rtl/tinyalu_wide.sv
// Wide TinyALU: control FSM, MUL latency counter, single-cycle datapath and
// registered done/busy/err/result outputs behind the start/done interface.
module tinyalu_wide
    import tinyalu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MULT_LAT = 3
) (
    input  logic           clk,
    input  logic           reset_n,
    tinyalu_wide_if.slave  bus
);
    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done_r;
    logic              busy_r;
    logic              err_r;
    logic [RW-1:0]     result_r;

    op_e               op_s;
    logic              accept_s;
    logic              mul_start_s;
    logic              mul_valid_s;
    logic [RW-1:0]     mul_prod_s;
    logic [RW-1:0]     single_res_s;

    assign op_s        = op_e'(bus.op);
    assign accept_s    = bus.start && !busy_r;
    assign mul_start_s = accept_s && (op_s == OP_MUL);

    tinyalu_mul_pipe #(
        .WIDTH    (WIDTH),
        .MULT_LAT (MULT_LAT)
    ) u_mul (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (mul_start_s),
        .a         (bus.A),
        .b         (bus.B),
        .out_valid (mul_valid_s),
        .product   (mul_prod_s)
    );

    // Single-cycle result mux; everything is computed at full result width.
    always_comb begin
        single_res_s = {RW{1'b0}};
        case (op_s)
            OP_ADD:  single_res_s = RW'(bus.A) + RW'(bus.B);
            OP_SUB:  single_res_s = RW'(bus.A) - RW'(bus.B);
            OP_AND:  single_res_s = RW'(bus.A & bus.B);
            OP_XOR:  single_res_s = RW'(bus.A ^ bus.B);
            OP_OR:   single_res_s = RW'(bus.A | bus.B);
            default: single_res_s = {RW{1'b0}};
        endcase
    end

    // Control FSM with latency counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= {RW{1'b0}};
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (op_s == OP_MUL) begin
                            if (MULT_LAT > 1) begin
                                state_r <= MUL_RUN;
                                busy_r  <= 1'b1;
                                cnt_r   <= CNT_W'(MULT_LAT - 2);
                            end else begin
                                done_r   <= 1'b1;
                                result_r <= mul_prod_s;
                            end
                        end else if (is_single_cycle(op_s)) begin
                            done_r   <= 1'b1;
                            err_r    <= (op_s == OP_ILL);
                            result_r <= single_res_s;
                        end else begin
                            result_r <= result_r;
                        end
                    end
                end
                MUL_RUN: begin
                    if (cnt_r == CNT_W'(0)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= mul_valid_s;
                        if (mul_valid_s) begin
                            result_r <= mul_prod_s;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    assign bus.err    = err_r;
    assign bus.result = result_r;
endmodule

// File: tb/tb_tinyalu_wide.sv
// Directed self-checking bench: default instance (8-bit, MULT_LAT=3) plus a
// 16-bit MULT_LAT=1 instance for the parameter sweep.
module tb_tinyalu_wide;

    logic clk = 1'b0;
    logic reset_n;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   done_seen;
    logic busy1_seen = 1'b0;

    tinyalu_wide_if #(.WIDTH(8))  bus0 ();
    tinyalu_wide_if #(.WIDTH(16)) bus1 ();

    tinyalu_wide #(.WIDTH(8), .MULT_LAT(3)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    tinyalu_wide #(.WIDTH(16), .MULT_LAT(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    always #5 clk = ~clk;

    // Watch for any busy on the single-cycle-MUL instance.
    always @(posedge clk) begin
        if (bus1.busy === 1'b1) busy1_seen <= 1'b1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd0(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus0.op    = op;
        bus0.A     = a;
        bus0.B     = b;
        bus0.start = 1'b1;
    endtask

    initial begin
        reset_n    = 1'b0;
        bus0.A     = 8'h00;
        bus0.B     = 8'h00;
        bus0.op    = 3'b000;
        bus0.start = 1'b0;
        bus1.A     = 16'h0000;
        bus1.B     = 16'h0000;
        bus1.op    = 3'b000;
        bus1.start = 1'b0;

        // Reset state
        repeat (2) tick();
        check_val("rst_done",   64'(bus0.done),   64'h0);
        check_val("rst_busy",   64'(bus0.busy),   64'h0);
        check_val("rst_err",    64'(bus0.err),    64'h0);
        check_val("rst_result", 64'(bus0.result), 64'h0);
        reset_n = 1'b1;
        repeat (3) tick();
        check_val("idle_done",   64'(bus0.done),   64'h0);
        check_val("idle_result", 64'(bus0.result), 64'h0);

        // ADD then SUB back-to-back
        cmd0(3'b001, 8'hFF, 8'h01);
        tick();
        check_val("add_done",   64'(bus0.done),   64'h1);
        check_val("add_result", 64'(bus0.result), 64'h0100);
        cmd0(3'b101, 8'h03, 8'h05);
        tick();
        check_val("sub_done",   64'(bus0.done),   64'h1);
        check_val("sub_result", 64'(bus0.result), 64'hFFFE);
        bus0.start = 1'b0;
        tick();
        check_val("sub_done_pulse", 64'(bus0.done),   64'h0);
        check_val("sub_hold",       64'(bus0.result), 64'hFFFE);

        // MUL FF*FF with an ignored ADD while busy
        cmd0(3'b100, 8'hFF, 8'hFF);
        tick();
        check_val("mul_busy_k1", 64'(bus0.busy), 64'h1);
        check_val("mul_done_k1", 64'(bus0.done), 64'h0);
        cmd0(3'b001, 8'h01, 8'h01);
        tick();
        check_val("mul_busy_k2", 64'(bus0.busy), 64'h1);
        check_val("mul_done_k2", 64'(bus0.done), 64'h0);
        bus0.start = 1'b0;
        tick();
        check_val("mul_done",   64'(bus0.done),   64'h1);
        check_val("mul_busy_0", 64'(bus0.busy),   64'h0);
        check_val("mul_result", 64'(bus0.result), 64'hFE01);
        check_val("mul_err",    64'(bus0.err),    64'h0);
        // Start in the MUL done cycle is accepted
        cmd0(3'b001, 8'h02, 8'h03);
        tick();
        check_val("post_mul_add_done",   64'(bus0.done),   64'h1);
        check_val("post_mul_add_result", 64'(bus0.result), 64'h0005);
        bus0.start = 1'b0;
        tick();
        check_val("post_mul_idle", 64'(bus0.done), 64'h0);

        // Reset mid-MUL
        cmd0(3'b100, 8'hFF, 8'hFF);
        tick();
        bus0.start = 1'b0;
        tick();
        check_val("mid_busy", 64'(bus0.busy), 64'h1);
        reset_n = 1'b0;
        #1;
        check_val("async_busy",   64'(bus0.busy),   64'h0);
        check_val("async_result", 64'(bus0.result), 64'h0);
        tick();
        check_val("mid_rst_done", 64'(bus0.done), 64'h0);
        check_val("mid_rst_err",  64'(bus0.err),  64'h0);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus0.done === 1'b1) done_seen++;
        end
        check_val("discarded_mul_done", 64'(done_seen), 64'h0);
        cmd0(3'b011, 8'hAA, 8'h55);
        tick();
        check_val("xor_done",   64'(bus0.done),   64'h1);
        check_val("xor_result", 64'(bus0.result), 64'h00FF);
        bus0.start = 1'b0;

        // Illegal opcode
        cmd0(3'b111, 8'h12, 8'h34);
        tick();
        check_val("ill_done",   64'(bus0.done),   64'h1);
        check_val("ill_err",    64'(bus0.err),    64'h1);
        check_val("ill_result", 64'(bus0.result), 64'h0);
        bus0.start = 1'b0;
        tick();
        check_val("ill_err_pulse", 64'(bus0.err), 64'h0);

        // NOP leaves result untouched
        cmd0(3'b110, 8'h01, 8'h02);
        tick();
        check_val("or_result", 64'(bus0.result), 64'h0003);
        cmd0(3'b000, 8'hFF, 8'hFF);
        tick();
        check_val("nop_done",   64'(bus0.done),   64'h0);
        check_val("nop_result", 64'(bus0.result), 64'h0003);
        check_val("nop_busy",   64'(bus0.busy),   64'h0);
        bus0.start = 1'b0;

        // WIDTH=16, MULT_LAT=1
        bus1.A     = 16'hFFFF;
        bus1.B     = 16'h0002;
        bus1.op    = 3'b100;
        bus1.start = 1'b1;
        tick();
        check_val("w16_mul_done",   64'(bus1.done),   64'h1);
        check_val("w16_mul_result", 64'(bus1.result), 64'h0001FFFE);
        check_val("w16_mul_err",    64'(bus1.err),    64'h0);
        bus1.start = 1'b0;
        tick();
        check_val("w16_done_pulse", 64'(bus1.done),   64'h0);
        check_val("w16_hold",       64'(bus1.result), 64'h0001FFFE);
        check_val("w16_never_busy", 64'(busy1_seen),  64'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/tinyalu_wide.md
# tinyalu_wide

Parametrised next-generation TinyALU datapath: width-generic operands, two extra operations (SUB, OR), a configurable-latency pipelined multiplier, a `busy` flag and an illegal-opcode `err` flag. It sits behind the existing TinyALU start/done command interface, so current drivers and monitors reuse it with only width changes. Single-cycle operations complete one cycle after `start`. MUL completes `MULT_LAT` cycles after `start`.

## Interface
- `WIDTH`, default 8: operand width in bits, 2 or more.
- `MULT_LAT`, default 3: cycles from the edge where a MUL `start` is sampled to the edge where `done` is sampled high, 1 or more.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `op` in 3: opcode.
  - 000 NOP, 001 ADD, 010 AND, 011 XOR.
  - 100 MUL, 101 SUB, 110 OR, 111 illegal.
- `start` in 1: command valid; sampled only when `busy`=0.
- `done` out 1: one-cycle completion pulse.
- `busy` out 1: MUL in flight; `start` is ignored while high.
- `err` out 1: high with `done` when the accepted op was 111.
- `result` out 2*WIDTH: registered result; holds its value between `done` pulses.

## Operation
- Reset (async, any time, including mid-MUL): `done`=0, `busy`=0, `err`=0, `result`=0, FSM to IDLE. Any in-flight MUL is discarded and never signals `done`.
- FSM states and transitions:
  - IDLE → MUL_RUN on accepted MUL when `MULT_LAT`>1.
  - MUL_RUN → IDLE when the cycle counter expires.
- Command accept: `start`=1 and `busy`=0 at a rising edge. `A`, `B` and `op` are captured at that edge, so they may change afterwards.
- NOP: no `done` and no state change; `result` holds.
- Arithmetic, with all results 2*WIDTH wide:
  - ADD: zero-extended sum.
  - SUB: (A−B) mod 2^(2*WIDTH), so the result wraps when B>A.
  - AND, XOR, OR: zero-extended bitwise result.
  - MUL: unsigned product.
- Illegal op 111: `done`=1, `err`=1, `result`=0.
- Back-to-back single-cycle ops are accepted on consecutive cycles; each produces its own `done` pulse.
- A `start` presented in the same cycle as a MUL `done` (when `busy` is already 0) is accepted.

## Timing
- Single-cycle op sampled at edge k: `done`=1 and `result` valid when sampled at edge k+1.
- MUL sampled at edge k:
  - `busy`=1 when sampled at edges k+1 … k+MULT_LAT−1.
  - `done`=1 and `result` valid when sampled at edge k+MULT_LAT.
  - `busy`=0 in the `done` cycle.
- `MULT_LAT`=1: MUL behaves like a single-cycle op and `busy` never asserts.
- `done` is never high for two consecutive cycles from one command.
- `err` is never high without `done`.
- While `busy`=1, `start` is ignored: no queueing and no `err`.

## Structure
- Package `tinyalu_pkg` holds:
  - `op_e` enum covering all eight opcodes.
  - `state_e` {IDLE, MUL_RUN}.
  - A function that reports whether an op is single-cycle.
- Sub-module `tinyalu_mul_pipe`, parameters WIDTH and MULT_LAT:
  - Registered-input unsigned multiplier with MULT_LAT−1 pipeline stages.
  - Valid bit travels alongside the data.
  - Cleared by `reset_n`.
- The top level contains the control FSM, the latency counter, single-cycle datapath muxing and output registers.

## Test plan
- Reset assertion: drive `reset_n`=0 mid-run → `done`=0, `busy`=0, `err`=0, `result`=0 at the following edge; release, then issue no commands → outputs stay at 0.
- Default params, ADD then SUB back-to-back:
  - ADD A=8'hFF, B=8'h01 → `result`=16'h0100, `done`=1 at k+1.
  - SUB A=3, B=5 → `result`=16'hFFFE at k+2.
- MUL with `MULT_LAT`=3, A=8'hFF, B=8'hFF at edge k:
  - `busy`=1 at k+1 and k+2.
  - `result`=16'hFE01 and `done`=1 at k+3.
  - `start`+ADD presented at k+1 is ignored.
- Reset mid-MUL: pull `reset_n` low at k+2 → no `done` ever appears for that command; a fresh XOR A=8'hAA, B=8'h55 after release → `result`=16'h00FF.
- Opcode edge cases: op=111 with `start` → `done`=1, `err`=1, `result`=0 next cycle; op=000 with `start` → no `done`, `result` unchanged.
- Parameter sweep: WIDTH=16, MULT_LAT=1, MUL A=16'hFFFF, B=16'h0002 → `result`=32'h0001FFFE at k+1 with `busy` never asserted.
